systolic_array_sched: RTL and testbench

SYSTOLIC_ARRAY_SCHED -- requirements
Module: systolic_array_sched

---
 rtl/systolic_array_sched.sv | 178 +++++++++++++++++
 tb/tb_systolic_array_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_sched.sv
// Job scheduler for a weight-stationary systolic array. It loads the weight rows,
// streams the input rows and tracks psum rows through the array pipeline with backpressure.
module systolic_array_sched #(
  parameter int ARRAY_SIZE = 8,
  parameter int PIPE_LAT   = 9,
  parameter int ROW_W      = 8,
  localparam int AW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [3:0]       cfg_in_width,
  input  logic [3:0]       cfg_weight_width,
  input  logic             cfg_s_in,
  input  logic             cfg_s_weight,
  input  logic [ROW_W-1:0] cfg_num_rows,
  output logic             cfg_err,
  output logic [AW-1:0]    wbuf_rd_addr,
  output logic             sa_weight_load,
  output logic [AW-1:0]    sa_weight_row,
  output logic [ROW_W-1:0] ibuf_rd_addr,
  output logic             sa_in_valid,
  output logic             sa_en,
  output logic [3:0]       sa_in_width,
  output logic [3:0]       sa_weight_width,
  output logic             sa_s_in,
  output logic             sa_s_weight,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wCnt_q, wCnt_d;
  logic [ROW_W-1:0]    rowCnt_q, rowCnt_d;
  logic [ROW_W-1:0]    numRows_q, numRows_d;
  logic [ROW_W-1:0]    outIdx_q, outIdx_d;
  logic [PIPE_LAT-1:0] validSr_q, validSr_d;
  logic [3:0]          inWidth_q, inWidth_d, wWidth_q, wWidth_d;
  logic                sIn_q, sIn_d, sW_q, sW_d;
  logic                accept, widthsOk, stall, outFire, issue, enable;

  function automatic logic legalWidth(input logic [3:0] w);
    return (w == 4'd1) || (w == 4'd2) || (w == 4'd4) || (w == 4'd8);
  endfunction

  assign cfg_ready = (state_q == IDLE) && !rst;
  assign accept    = cfg_valid && cfg_ready;
  assign widthsOk  = legalWidth(cfg_in_width) && legalWidth(cfg_weight_width);
  assign out_valid = validSr_q[PIPE_LAT-1];
  // A psum row that downstream refuses freezes the whole array, including issue.
  assign stall     = out_valid && !out_ready;
  assign outFire   = out_valid && out_ready;

  assign sa_en           = enable;
  assign sa_in_valid     = issue;
  assign sa_in_width     = inWidth_q;
  assign sa_weight_width = wWidth_q;
  assign sa_s_in         = sIn_q;
  assign sa_s_weight     = sW_q;
  assign out_row_idx     = outIdx_q;

  always_comb begin
    state_d        = state_q;
    wCnt_d         = wCnt_q;
    rowCnt_d       = rowCnt_q;
    numRows_d      = numRows_q;
    outIdx_d       = outIdx_q;
    inWidth_d      = inWidth_q;
    wWidth_d       = wWidth_q;
    sIn_d          = sIn_q;
    sW_d           = sW_q;
    enable         = 1'b0;
    issue          = 1'b0;
    cfg_err        = 1'b0;
    sa_weight_load = 1'b0;
    wbuf_rd_addr   = '0;
    sa_weight_row  = '0;
    ibuf_rd_addr   = '0;
    busy           = 1'b0;
    done           = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!widthsOk) begin
            cfg_err = 1'b1;
          end else begin
            inWidth_d = cfg_in_width;
            wWidth_d  = cfg_weight_width;
            sIn_d     = cfg_s_in;
            sW_d      = cfg_s_weight;
            numRows_d = cfg_num_rows;
            wCnt_d    = '0;
            rowCnt_d  = '0;
            outIdx_d  = '0;
            state_d   = LOAD_W;
          end
        end
      end
      LOAD_W: begin
        busy           = 1'b1;
        enable         = 1'b1;
        sa_weight_load = 1'b1;
        wbuf_rd_addr   = wCnt_q;
        sa_weight_row  = wCnt_q;
        if (wCnt_q == AW'(ARRAY_SIZE - 1)) begin
          wCnt_d  = '0;
          state_d = (numRows_q == '0) ? DONE : COMPUTE;
        end else begin
          wCnt_d = wCnt_q + 1'b1;
        end
      end
      COMPUTE: begin
        busy         = 1'b1;
        enable       = !stall;
        ibuf_rd_addr = rowCnt_q;
        if (!stall) begin
          issue    = 1'b1;
          rowCnt_d = rowCnt_q + 1'b1;
          if (rowCnt_q == numRows_q - 1'b1) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        busy   = 1'b1;
        enable = !stall;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    validSr_d = enable ? ((validSr_q << 1) | PIPE_LAT'(issue)) : validSr_q;
    if (outFire) begin
      outIdx_d = outIdx_q + 1'b1;
    end
    // Finish only once the last row has left and nothing remains in flight.
    if ((state_q == DRAIN) && (validSr_d == '0)) begin
      state_d = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wCnt_q    <= '0;
      rowCnt_q  <= '0;
      numRows_q <= '0;
      outIdx_q  <= '0;
      validSr_q <= '0;
      inWidth_q <= '0;
      wWidth_q  <= '0;
      sIn_q     <= 1'b0;
      sW_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wCnt_q    <= wCnt_d;
      rowCnt_q  <= rowCnt_d;
      numRows_q <= numRows_d;
      outIdx_q  <= outIdx_d;
      validSr_q <= validSr_d;
      inWidth_q <= inWidth_d;
      wWidth_q  <= wWidth_d;
      sIn_q     <= sIn_d;
      sW_q      <= sW_d;
    end
  end

endmodule

// File: tb/tb_systolic_array_sched.sv
// Directed bench for systolic_array_sched (ARRAY_SIZE=8, PIPE_LAT=9, ROW_W=8).
// Expected timelines are written relative to the descriptor accept cycle (cycle 0).
module tb_systolic_array_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_in_width;
  logic [3:0] cfg_weight_width;
  logic       cfg_s_in;
  logic       cfg_s_weight;
  logic [7:0] cfg_num_rows;
  logic       cfg_err;
  logic [2:0] wbuf_rd_addr;
  logic       sa_weight_load;
  logic [2:0] sa_weight_row;
  logic [7:0] ibuf_rd_addr;
  logic       sa_in_valid;
  logic       sa_en;
  logic [3:0] sa_in_width;
  logic [3:0] sa_weight_width;
  logic       sa_s_in;
  logic       sa_s_weight;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_row_idx;
  logic       busy;
  logic       done;

  int compared   = 0;
  int mismatched = 0;

  systolic_array_sched #(.ARRAY_SIZE(8), .PIPE_LAT(9), .ROW_W(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_in_width(cfg_in_width), .cfg_weight_width(cfg_weight_width),
    .cfg_s_in(cfg_s_in), .cfg_s_weight(cfg_s_weight),
    .cfg_num_rows(cfg_num_rows), .cfg_err(cfg_err),
    .wbuf_rd_addr(wbuf_rd_addr), .sa_weight_load(sa_weight_load),
    .sa_weight_row(sa_weight_row), .ibuf_rd_addr(ibuf_rd_addr),
    .sa_in_valid(sa_in_valid), .sa_en(sa_en),
    .sa_in_width(sa_in_width), .sa_weight_width(sa_weight_width),
    .sa_s_in(sa_s_in), .sa_s_weight(sa_s_weight),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row_idx(out_row_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] inW,
                               input logic [3:0] wW, input logic sIn,
                               input logic sW, input logic [7:0] n,
                               input logic ready);
    cfg_valid        = valid;
    cfg_in_width     = inW;
    cfg_weight_width = wW;
    cfg_s_in         = sIn;
    cfg_s_weight     = sW;
    cfg_num_rows     = n;
    out_ready        = ready;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one legal job from its accept cycle through DONE, checking every cycle.
  // stallLen holds out_ready low starting at the first out_valid (needs n <= 9).
  // holdValid keeps a different descriptor (8/8, one row) pending during the job.
  task automatic runJob(input string tag, input logic [3:0] inW, input logic [3:0] wW,
                        input logic sIn, input logic sW, input logic [7:0] n,
                        input int stallLen, input bit holdValid);
    int doneCyc;
    int enLow;
    int delivered;
    string t;
    bit stallC, expLoad, expIssue, expOut, expEn;
    int nr;
    nr = int'(n);
    doneCyc = (nr == 0) ? 9 : 18 + stallLen + nr;
    enLow = 0;
    delivered = 0;
    applyStimulus(1'b1, inW, wW, sIn, sW, n, 1'b1);
    @(negedge clk);
    checkOutput({tag, " c0 cfg_ready"}, 32'(cfg_ready), 1);
    checkOutput({tag, " c0 cfg_err"}, 32'(cfg_err), 0);
    checkOutput({tag, " c0 busy"}, 32'(busy), 0);
    nextCycle();
    for (int c = 1; c <= doneCyc; c++) begin
      t = $sformatf("%s c%0d", tag, c);
      stallC   = (stallLen > 0) && (c >= 18) && (c <= 17 + stallLen);
      expLoad  = (c <= 8);
      expIssue = (nr > 0) && (c >= 9) && (c <= 8 + nr);
      expOut   = (nr > 0) && (c >= 18) && (c <= 17 + stallLen + nr);
      expEn    = expLoad || ((nr > 0) && (c >= 9) && (c < doneCyc) && !stallC);
      if (holdValid) applyStimulus(1'b1, 4'd8, 4'd8, 1'b0, 1'b0, 8'd1, !stallC);
      else           applyStimulus(1'b0, inW, wW, sIn, sW, n, !stallC);
      @(negedge clk);
      checkOutput({t, " weight_load"}, 32'(sa_weight_load), 32'(expLoad));
      checkOutput({t, " in_valid"}, 32'(sa_in_valid), 32'(expIssue));
      checkOutput({t, " sa_en"}, 32'(sa_en), 32'(expEn));
      checkOutput({t, " out_valid"}, 32'(out_valid), 32'(expOut));
      checkOutput({t, " busy"}, 32'(busy), 32'(c < doneCyc));
      checkOutput({t, " done"}, 32'(done), 32'(c == doneCyc));
      checkOutput({t, " cfg_ready"}, 32'(cfg_ready), 0);
      checkOutput({t, " sa_in_width"}, 32'(sa_in_width), 32'(inW));
      if (expLoad) begin
        checkOutput({t, " wbuf_addr"}, 32'(wbuf_rd_addr), c - 1);
        checkOutput({t, " weight_row"}, 32'(sa_weight_row), c - 1);
      end else begin
        checkOutput({t, " wbuf_addr idle"}, 32'(wbuf_rd_addr), 0);
      end
      if (expIssue) checkOutput({t, " ibuf_addr"}, 32'(ibuf_rd_addr), c - 9);
      if (expOut) begin
        checkOutput({t, " out_row_idx"}, 32'(out_row_idx),
                    (c < 18 + stallLen) ? 0 : c - 18 - stallLen);
      end
      if (c == 1) begin
        checkOutput({t, " sa_weight_width"}, 32'(sa_weight_width), 32'(wW));
        checkOutput({t, " sa_s_in"}, 32'(sa_s_in), 32'(sIn));
        checkOutput({t, " sa_s_weight"}, 32'(sa_s_weight), 32'(sW));
        checkOutput({t, " out_row_idx start"}, 32'(out_row_idx), 0);
      end
      if (busy && !sa_en) enLow++;
      if (out_valid && out_ready) delivered++;
      nextCycle();
    end
    checkOutput({tag, " stall cycles"}, enLow, stallLen);
    checkOutput({tag, " rows delivered"}, delivered, nr);
  endtask

  task automatic checkIdle(input string tag);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b1);
    @(negedge clk);
    checkOutput({tag, " idle cfg_ready"}, 32'(cfg_ready), 1);
    checkOutput({tag, " idle busy"}, 32'(busy), 0);
    checkOutput({tag, " idle done"}, 32'(done), 0);
    checkOutput({tag, " idle sa_en"}, 32'(sa_en), 0);
    nextCycle();
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b1);
    @(negedge clk);
    checkOutput("rst cfg_ready", 32'(cfg_ready), 0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset cfg_ready", 32'(cfg_ready), 1);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset out_valid", 32'(out_valid), 0);
    checkOutput("reset sa_en", 32'(sa_en), 0);
    checkOutput("reset sa_in_width", 32'(sa_in_width), 0);
    checkOutput("reset sa_weight_width", 32'(sa_weight_width), 0);
    checkOutput("reset sa_s_in", 32'(sa_s_in), 0);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset cfg_err", 32'(cfg_err), 0);
    checkOutput("reset out_row_idx", 32'(out_row_idx), 0);
    nextCycle();

    runJob("nominal", 4'd2, 4'd2, 1'b0, 1'b0, 8'd4, 0, 1'b0);
    checkIdle("nominal");

    // Illegal in_width, then illegal weight_width: rejected, config untouched.
    applyStimulus(1'b1, 4'd3, 4'd2, 1'b1, 1'b1, 8'd4, 1'b1);
    @(negedge clk);
    checkOutput("illegal in cfg_err", 32'(cfg_err), 1);
    checkOutput("illegal in cfg_ready", 32'(cfg_ready), 1);
    nextCycle();
    applyStimulus(1'b1, 4'd4, 4'd0, 1'b1, 1'b1, 8'd4, 1'b1);
    @(negedge clk);
    checkOutput("illegal w cfg_err", 32'(cfg_err), 1);
    checkOutput("illegal w busy", 32'(busy), 0);
    checkOutput("illegal w sa_in_width", 32'(sa_in_width), 2);
    nextCycle();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b1);
    @(negedge clk);
    checkOutput("after illegal cfg_err", 32'(cfg_err), 0);
    checkOutput("after illegal busy", 32'(busy), 0);
    checkOutput("after illegal cfg_ready", 32'(cfg_ready), 1);
    checkOutput("after illegal sa_in_width", 32'(sa_in_width), 2);
    checkOutput("after illegal sa_weight_width", 32'(sa_weight_width), 2);
    checkOutput("after illegal sa_s_in", 32'(sa_s_in), 0);
    checkOutput("after illegal sa_en", 32'(sa_en), 0);
    nextCycle();

    runJob("backpressure", 4'd4, 4'd8, 1'b1, 1'b0, 8'd3, 5, 1'b0);
    checkIdle("backpressure");

    runJob("zero rows", 4'd8, 4'd1, 1'b0, 1'b1, 8'd0, 0, 1'b0);
    checkIdle("zero rows");

    // Abort a six-row job while its third row is being issued.
    applyStimulus(1'b1, 4'd2, 4'd4, 1'b0, 1'b0, 8'd6, 1'b1);
    nextCycle();
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(1'b0, 4'd2, 4'd4, 1'b0, 1'b0, 8'd6, 1'b1);
      @(negedge clk);
      if (c >= 9) checkOutput($sformatf("abort c%0d in_valid", c), 32'(sa_in_valid), 1);
      nextCycle();
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort rst cfg_ready", 32'(cfg_ready), 0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", 32'(busy), 0);
    checkOutput("abort sa_in_width", 32'(sa_in_width), 0);
    checkOutput("abort cfg_ready", 32'(cfg_ready), 1);
    for (int c = 0; c < 20; c++) begin
      checkOutput($sformatf("abort +%0d out_valid", c), 32'(out_valid), 0);
      checkOutput($sformatf("abort +%0d done", c), 32'(done), 0);
      nextCycle();
      @(negedge clk);
    end
    nextCycle();

    runJob("after reset", 4'd1, 4'd1, 1'b1, 1'b1, 8'd2, 0, 1'b0);
    checkIdle("after reset");

    runJob("held valid", 4'd4, 4'd1, 1'b0, 1'b0, 8'd2, 0, 1'b1);
    runJob("back-to-back", 4'd8, 4'd8, 1'b0, 1'b0, 8'd1, 0, 1'b0);
    checkIdle("back-to-back");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
